// File: rtl/neuron_mac_if.sv
// neuron_mac handshake bundle: start/bias, pair stream, result.
// master drives stimulus, slave is the MAC stage.
interface neuron_mac_if #(
    parameter int DWIDTH = 32
);
    logic              start;
    logic [DWIDTH-1:0] bias;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] x_in;
    logic [DWIDTH-1:0] w_in;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] sum_out;
    logic              busy;

    modport master (
        output start, bias, in_valid, x_in, w_in, out_ready,
        input  in_ready, out_valid, sum_out, busy
    );

    modport slave (
        input  start, bias, in_valid, x_in, w_in, out_ready,
        output in_ready, out_valid, sum_out, busy
    );
endinterface

// File: rtl/neuron_mac.sv
// Q8.24 per-neuron MAC: bias + sum(x*w) over N_IN pairs.
// Define NEURON_MAC_SAT_EN for saturating product and accumulate.
module neuron_mac #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int N_IN   = 4,
    parameter int CNT_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    neuron_mac_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

    state_t                     state;
    logic [DWIDTH-1:0]          acc;
    logic [CNT_W-1:0]           cnt;
    logic                       out_valid_q;
    logic [DWIDTH-1:0]          sum_q;

    logic signed [2*DWIDTH-1:0] prod;
    logic [DWIDTH-1:0]          p;
    logic [DWIDTH-1:0]          sum_n;
    logic                       unused_bits;

`ifdef NEURON_MAC_SAT_EN
    localparam logic [DWIDTH-1:0] MAXV = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] MINV = {1'b1, {(DWIDTH-1){1'b0}}};

    logic [DWIDTH-FRAC:0] hi;

    // Product rescale and accumulate, clamped at the Q8.24 limits.
    always_comb begin
        prod  = $signed(bus.x_in) * $signed(bus.w_in);
        hi    = prod[2*DWIDTH-1:DWIDTH-1+FRAC];
        p     = prod[DWIDTH-1+FRAC:FRAC];
        if (!(&hi) && (|hi))
            p = prod[2*DWIDTH-1] ? MINV : MAXV;
        sum_n = acc + p;
        if (acc[DWIDTH-1] == p[DWIDTH-1] &&
            sum_n[DWIDTH-1] != acc[DWIDTH-1])
            sum_n = acc[DWIDTH-1] ? MINV : MAXV;
        unused_bits = ^prod[FRAC-1:0];
    end
`else
    // Product rescale (floor) and wrapping accumulate.
    always_comb begin
        prod        = $signed(bus.x_in) * $signed(bus.w_in);
        p           = prod[DWIDTH-1+FRAC:FRAC];
        sum_n       = acc + p;
        unused_bits = ^{prod[2*DWIDTH-1:DWIDTH+FRAC], prod[FRAC-1:0]};
    end
`endif

    assign bus.in_ready  = (state == ACC);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum_out   = sum_q;

    // Evaluation FSM: load bias, take N_IN pairs, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc   <= bus.bias;
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        acc <= sum_n;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            sum_q       <= sum_n;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed Q8.24 vectors, queued expectations.
// Monitor pops and compares on every out_valid/out_ready handshake.
module tb_neuron_mac;
    localparam int DW = 32;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] expq[$];

    always #5 clk = ~clk;

    neuron_mac_if #(.DWIDTH(DW)) bus ();

    neuron_mac #(
        .DWIDTH(DW),
        .FRAC  (24),
        .N_IN  (N),
        .CNT_W (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Result monitor: compare every consumed sum with the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got %h expected none",
                         bus.sum_out);
            end else begin
                chk("sum_out", bus.sum_out, expq.pop_front());
            end
        end
    end

    task automatic do_start(input logic [DW-1:0] b);
        bus.start = 1'b1;
        bus.bias  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic consume(input string nm);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({nm, "_busy_after"}, DW'(bus.busy), '0);
        chk({nm, "_ov_after"}, DW'(bus.out_valid), '0);
        @(posedge clk); #1;
    endtask

    task automatic run(input string nm, input logic [DW-1:0] b,
                       input logic [DW-1:0] xv[N],
                       input logic [DW-1:0] wv[N],
                       input logic [DW-1:0] exp);
        expq.push_back(exp);
        do_start(b);
        chk({nm, "_in_ready"}, DW'(bus.in_ready), 1);
        chk({nm, "_busy"}, DW'(bus.busy), 1);
        for (int i = 0; i < N; i++) begin
            bus.in_valid = 1'b1;
            bus.x_in     = xv[i];
            bus.w_in     = wv[i];
            @(posedge clk); #1;
            if (i < N - 1)
                chk({nm, "_ov_early"}, DW'(bus.out_valid), 0);
        end
        bus.in_valid = 1'b0;
        chk({nm, "_ov_latency"}, DW'(bus.out_valid), 1);
        chk({nm, "_in_ready_done"}, DW'(bus.in_ready), 0);
        consume(nm);
    endtask

    task automatic run_const(input string nm, input logic [DW-1:0] b,
                             input logic [DW-1:0] x,
                             input logic [DW-1:0] w,
                             input logic [DW-1:0] exp);
        logic [DW-1:0] xv[N];
        logic [DW-1:0] wv[N];
        for (int i = 0; i < N; i++) begin
            xv[i] = x;
            wv[i] = w;
        end
        run(nm, b, xv, wv, exp);
    endtask

    initial begin
        logic [DW-1:0] xv[N];
        logic [DW-1:0] wv[N];
        logic [6:0]    pat;
        int            k;

        bus.start     = 1'b0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.w_in      = '0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_in_ready", DW'(bus.in_ready), 0);
        chk("rst_out_valid", DW'(bus.out_valid), 0);
        chk("rst_sum_out", bus.sum_out, 0);
        chk("rst_busy", DW'(bus.busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_const("basic", 32'h0080_0000, 32'h0100_0000,
                  32'h0040_0000, 32'h0180_0000);
        run_const("neg", 32'h0, 32'hFE00_0000,
                  32'h0080_0000, 32'hFC00_0000);

        // Stalled input stream: only handshake cycles count.
        pat = 7'b1101001;
        expq.push_back(32'h0400_0000);
        do_start(32'h0);
        bus.x_in = 32'h0100_0000;
        bus.w_in = 32'h0100_0000;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = pat[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("stall_ov", DW'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 1);
            @(posedge clk); #1;
            chk("hold_ov", DW'(bus.out_valid), 1);
            chk("hold_sum", bus.sum_out, 32'h0400_0000);
            chk("hold_in_ready", DW'(bus.in_ready), 0);
        end
        bus.start = 1'b0;
        consume("stall");
        chk("stall_idle", DW'(bus.busy), 0);

        // Asynchronous reset after two of four pairs.
        do_start(32'h0100_0000);
        bus.x_in = 32'h0100_0000;
        bus.w_in = 32'h0100_0000;
        bus.in_valid = 1'b1;
        for (k = 0; k < 2; k++) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", DW'(bus.in_ready), 0);
        chk("arst_out_valid", DW'(bus.out_valid), 0);
        chk("arst_sum_out", bus.sum_out, 0);
        chk("arst_busy", DW'(bus.busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_const("post_rst", 32'h0, 32'h0100_0000,
                  32'h0020_0000, 32'h0080_0000);

`ifdef NEURON_MAC_SAT_EN
        run_const("ovf", 32'h0, 32'h6400_0000,
                  32'h0100_0000, 32'h7FFF_FFFF);
`else
        run_const("ovf", 32'h0, 32'h6400_0000,
                  32'h0100_0000, 32'h9000_0000);
`endif

        xv = '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
        wv = '{32'hFF00_0000, 32'h0100_0000,
               32'h0100_0000, 32'h0100_0000};
        run("trunc", 32'h0, xv, wv, 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", DW'(expq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
